load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side controller for the 8-bit, 32-entry data memory.
- Accepts load/store requests of 1–4 bytes from the CPU datapath over a valid/ready handshake.
- Sequences one memory access per byte on the memoryWrite/memory_read strobes and returns packed read data plus an error flag over a valid/ready response channel.
- Performs the address range check the memory itself lacks.

Parameters:
- ADDR_W, 8, width of memory_address and req_addr.
- MEM_DEPTH, 32, number of valid byte locations; addresses >= MEM_DEPTH are out of range.
- READ_LAT, 1, extra cycles memory_read is held before read data is sampled (0..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  base byte address.
- req_len  input  2  beat count minus 1 (0 → 1 byte, 3 → 4 bytes).
- req_wdata  input  32  store data; byte i is bits [8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load data; byte i in bits [8i+7:8i]; unused lanes are 0.
- rsp_err  output  1  one or more beats were out of range.
- memoryWrite  output  1  memory write strobe.
- memory_read  output  1  memory read strobe.
- memory_address  output  ADDR_W  memory address.
- memory_datawrite  output  8  memory write data.
- memory_read_data  input  8  memory read data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - memoryWrite=0; memory_read=0; memory_address=0; memory_datawrite=0.
  - Reset mid-operation aborts immediately; strobes drop without waiting for a clock. Beats already written stay in memory.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1 only in IDLE.
  - On a clk edge with req_valid=1, latch req_write, req_addr, req_len and req_wdata.
  - Clear the rdata accumulator and err, set beat=0, go to ISSUE.
- Beat address = (req_addr + beat) mod 2^ADDR_W. The beat is in range when this address < MEM_DEPTH.
- ISSUE:
  - memory_address = beat address; memory_datawrite = wdata byte[beat].
  - In-range store: memoryWrite=1 for exactly this one cycle.
  - In-range load: memory_read=1. If READ_LAT=0, sample memory_read_data into lane[beat] at the end of this cycle; otherwise go to WAIT.
  - Out-of-range beat: no strobe, lane stays 0, err is set. Takes one cycle.
- WAIT:
  - memory_read stays 1 and memory_address is held.
  - Stays READ_LAT cycles; memory_read_data is sampled at the end of the last WAIT cycle.
- After each beat: if beat == req_len go to RESP, else increment beat and return to ISSUE. Strobes deassert for at least one cycle between beats only when the state passes through RESP/IDLE; back-to-back beats may keep a strobe high with a changed address.
- Beat timing:
  - Store beat: 1 cycle.
  - In-range load beat: 1 + READ_LAT cycles.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - memoryWrite=0 and memory_read=0.
  - When rsp_ready=1 at a clk edge, go to IDLE and clear rsp_valid. rsp_rdata keeps its value until the next response.
- Latency: from the request-accept edge, rsp_valid rises after N_store = (req_len+1)+1 cycles for stores and N_load = (req_len+1)(1+READ_LAT)+1 cycles for loads (all beats in range).
- For stores, rsp_rdata is 0.
- Address wrap: 255 + 1 wraps to 0, and 0 is in range.
- Strobe invariant: memoryWrite and memory_read are never both 1.
- No new request is accepted until the response handshake completes.

Optional Feature:
- Macro LSU_STATS_EN.
- When defined, adds three outputs: stat_loads (16 bits), stat_stores (16 bits) and stat_errs (16 bits).
  - stat_loads and stat_stores count completed responses by type.
  - stat_errs counts responses with rsp_err=1.
  - All three saturate at 0xFFFF and reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single store, then single load: store addr 0x03, len 0, wdata 0x000000A5 → exactly one memoryWrite cycle at address 0x03. Load 0x03 → rsp_rdata=0x000000A5, rsp_err=0. With READ_LAT=1, rsp_valid rises 3 cycles after the accept edge.
- Burst store and burst load: store addr 0x1C, len 3, wdata 0x44332211 → memoryWrite on addresses 0x1C..0x1F with data 11, 22, 33, 44. Burst load of the same range → rsp_rdata=0x44332211.
- Out-of-range beats: load addr 0x1E, len 3 → addresses 0x1E and 0x1F are read; beats at 0x20 and 0x21 produce no strobe. rsp_rdata upper 16 bits are 0; rsp_err=1.
- Wrap-around: store addr 0xFF, len 1 → the 0xFF beat has no strobe, the 0x00 beat is written with byte1; rsp_err=1.
- Response backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid stays 1 with data stable, req_ready=0, and a new req_valid is not accepted.
- Reset mid-load: assert rst_n=0 during WAIT → memory_read drops immediately and no response is issued. After release, req_ready=1. With LSU_STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte-serial load/store controller for the 8-bit data memory, with range checking.
// Optional response statistics counters are enabled by defining LSU_STATS_EN.
module load_store_unit #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              memoryWrite,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic [7:0]        memory_datawrite,
  input  logic [7:0]        memory_read_data
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state, w_nxt_state;
  logic              r_write, w_nxt_write;
  logic [ADDR_W-1:0] r_addr, w_nxt_addr;
  logic [1:0]        r_len, w_nxt_len;
  logic [31:0]       r_wdata, w_nxt_wdata;
  logic [1:0]        r_beat, w_nxt_beat;
  logic [1:0]        r_wait, w_nxt_wait;
  logic [31:0]       r_acc, w_nxt_acc;
  logic              r_err, w_nxt_err;
  logic              r_req_ready, w_nxt_req_ready;
  logic              r_rsp_valid, w_nxt_rsp_valid;
  logic [31:0]       r_rsp_rdata, w_nxt_rsp_rdata;
  logic              r_rsp_err, w_nxt_rsp_err;
  logic              r_mem_wr, w_nxt_mem_wr;
  logic              r_mem_rd, w_nxt_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr, w_nxt_mem_addr;
  logic [7:0]        r_mem_wdata, w_nxt_mem_wdata;

  logic [ADDR_W-1:0] w_cur_addr, w_nxt_beat_addr;
  logic              w_cur_in, w_nxt_in, w_beat_done, w_sample;

  assign w_cur_addr = r_addr + ADDR_W'(r_beat);
  assign w_cur_in   = 32'(w_cur_addr) < MEM_DEPTH;

  // Next state plus next values of every registered output.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_write     = r_write;
    w_nxt_addr      = r_addr;
    w_nxt_len       = r_len;
    w_nxt_wdata     = r_wdata;
    w_nxt_beat      = r_beat;
    w_nxt_wait      = r_wait;
    w_nxt_acc       = r_acc;
    w_nxt_err       = r_err;
    w_nxt_rsp_valid = r_rsp_valid;
    w_nxt_rsp_rdata = r_rsp_rdata;
    w_nxt_rsp_err   = r_rsp_err;
    w_nxt_mem_wr    = 1'b0;
    w_nxt_mem_rd    = 1'b0;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_wdata = r_mem_wdata;
    w_beat_done     = 1'b0;
    w_sample        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_nxt_write = req_write;
          w_nxt_addr  = req_addr;
          w_nxt_len   = req_len;
          w_nxt_wdata = req_wdata;
          w_nxt_acc   = 32'd0;
          w_nxt_err   = 1'b0;
          w_nxt_beat  = 2'd0;
          w_nxt_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!w_cur_in) begin
          w_nxt_err   = 1'b1;
          w_beat_done = 1'b1;
        end else if (r_write) begin
          w_beat_done = 1'b1;
        end else if (READ_LAT == 0) begin
          w_sample    = 1'b1;
          w_beat_done = 1'b1;
        end else begin
          w_nxt_wait  = 2'd0;
          w_nxt_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait == 2'(READ_LAT - 1)) begin
          w_sample    = 1'b1;
          w_beat_done = 1'b1;
        end else begin
          w_nxt_wait = r_wait + 2'd1;
        end
      end
      S_RESP: begin
        // First RESP cycle publishes the accumulator; later cycles wait for the handshake.
        if (!r_rsp_valid) begin
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_rdata = r_acc;
          w_nxt_rsp_err   = r_err;
        end else if (rsp_ready) begin
          w_nxt_rsp_valid = 1'b0;
          w_nxt_state     = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    if (w_sample) w_nxt_acc[{r_beat, 3'b000} +: 8] = memory_read_data;

    if (w_beat_done) begin
      if (r_beat == r_len) begin
        w_nxt_state = S_RESP;
      end else begin
        w_nxt_beat  = r_beat + 2'd1;
        w_nxt_state = S_ISSUE;
      end
    end

    w_nxt_beat_addr = w_nxt_addr + ADDR_W'(w_nxt_beat);
    w_nxt_in        = 32'(w_nxt_beat_addr) < MEM_DEPTH;

    if (w_nxt_state == S_ISSUE) begin
      w_nxt_mem_addr  = w_nxt_beat_addr;
      w_nxt_mem_wdata = w_nxt_wdata[{w_nxt_beat, 3'b000} +: 8];
      w_nxt_mem_wr    = w_nxt_write && w_nxt_in;
      w_nxt_mem_rd    = !w_nxt_write && w_nxt_in;
    end else if (w_nxt_state == S_WAIT) begin
      w_nxt_mem_rd = 1'b1;
    end

    w_nxt_req_ready = (w_nxt_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_len       <= 2'd0;
      r_wdata     <= 32'd0;
      r_beat      <= 2'd0;
      r_wait      <= 2'd0;
      r_acc       <= 32'd0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_state     <= w_nxt_state;
      r_write     <= w_nxt_write;
      r_addr      <= w_nxt_addr;
      r_len       <= w_nxt_len;
      r_wdata     <= w_nxt_wdata;
      r_beat      <= w_nxt_beat;
      r_wait      <= w_nxt_wait;
      r_acc       <= w_nxt_acc;
      r_err       <= w_nxt_err;
      r_req_ready <= w_nxt_req_ready;
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp_rdata <= w_nxt_rsp_rdata;
      r_rsp_err   <= w_nxt_rsp_err;
      r_mem_wr    <= w_nxt_mem_wr;
      r_mem_rd    <= w_nxt_mem_rd;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
    end
  end

  assign req_ready        = r_req_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_err          = r_rsp_err;
  assign memoryWrite      = r_mem_wr;
  assign memory_read      = r_mem_rd;
  assign memory_address   = r_mem_addr;
  assign memory_datawrite = r_mem_wdata;

`ifdef LSU_STATS_EN
  logic        w_rsp_fire;
  logic [15:0] r_stat_loads, r_stat_stores, r_stat_errs;

  assign w_rsp_fire = (r_state == S_RESP) && r_rsp_valid && rsp_ready;

  // Saturating per-response counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_loads  <= 16'd0;
      r_stat_stores <= 16'd0;
      r_stat_errs   <= 16'd0;
    end else if (w_rsp_fire) begin
      if (r_write && r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
      if (!r_write && r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
      if (r_rsp_err && r_stat_errs != 16'hFFFF) r_stat_errs <= r_stat_errs + 16'd1;
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, mid-load reset, random requests.
module tb_load_store_unit;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [1:0]  req_len = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        memoryWrite, memory_read;
  logic [7:0]  memory_address, memory_datawrite, memory_read_data;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  load_store_unit #(.ADDR_W(8), .MEM_DEPTH(32), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .memoryWrite(memoryWrite), .memory_read(memory_read), .memory_address(memory_address),
    .memory_datawrite(memory_datawrite), .memory_read_data(memory_read_data)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int exp_rd_cycles = 0;
  int n_loads = 0, n_stores = 0, n_errs = 0;
  logic [7:0]  dev_mem [32];
  logic [7:0]  ref_mem [32];
  logic [15:0] wlog[$];
  logic [15:0] exp_wlog[$];

  // Memory device: no range check, aliases on the low address bits.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) dev_mem[i] <= 8'(i * 7 + 3);
    end else if (memoryWrite) begin
      dev_mem[memory_address[4:0]] <= memory_datawrite;
    end
  end
  assign memory_read_data = dev_mem[memory_address[4:0]];

  always @(negedge clk) begin
    if (memoryWrite) wlog.push_back({memory_address, memory_datawrite});
    if (memory_read) rd_cycles++;
    if (memoryWrite && memory_read) begin
      errors++;
      $display("FAIL strobe_excl: memoryWrite=1 and memory_read=1 at %0t, required never both", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ref_init();
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 7 + 3);
  endtask

  // Reference: walk beats by address arithmetic and accumulate expected results.
  task automatic model(input logic w, input logic [7:0] a, input logic [1:0] l, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
    rd = 32'd0; err = 1'b0; lat = 1;
    exp_wlog.delete();
    exp_rd_cycles = 0;
    for (int i = 0; i <= int'(l); i++) begin
      logic [7:0] aa;
      aa = a + 8'(i);
      if (int'(aa) < 32) begin
        if (w) begin
          ref_mem[aa[4:0]] = wd[8*i +: 8];
          exp_wlog.push_back({aa, wd[8*i +: 8]});
          lat += 1;
        end else begin
          rd[8*i +: 8] = ref_mem[aa[4:0]];
          exp_rd_cycles += 1 + RL;
          lat += 1 + RL;
        end
      end else begin
        err = 1'b1;
        lat += 1;
      end
    end
  endtask

  task automatic run_req(input string name, input logic w, input logic [7:0] a, input logic [1:0] l,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int hold);
    int cyc;
    logic [31:0] held;
    @(negedge clk);
    chk({name, " req_ready_idle"}, 32'(req_ready), 32'd1);
    req_write = w; req_addr = a; req_len = l; req_wdata = wd; req_valid = 1'b1;
    wlog.delete();
    rd_cycles = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, " req_ready_busy"}, 32'(req_ready), 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(exp_lat));
    held = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      req_write = 1'b1; req_addr = 8'd0; req_len = 2'd0; req_valid = 1'b1;
      @(posedge clk); #1;
      chk({name, " bp_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, " bp_stable"}, rsp_rdata, held);
      chk({name, " bp_req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk({name, " rdata"}, rsp_rdata, exp_rd);
    chk({name, " err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, " valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({name, " ready_back"}, 32'(req_ready), 32'd1);
    chk({name, " rdata_kept"}, rsp_rdata, exp_rd);
    chk({name, " wr_count"}, 32'(wlog.size()), 32'(exp_wlog.size()));
    for (int i = 0; i < wlog.size() && i < exp_wlog.size(); i++)
      chk({name, " wr_beat"}, 32'(wlog[i]), 32'(exp_wlog[i]));
    chk({name, " rd_cycles"}, 32'(rd_cycles), 32'(exp_rd_cycles));
    if (w) n_stores++; else n_loads++;
    if (exp_err) n_errs++;
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [7:0]  a;
    logic [1:0]  l;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat;
    logic [7:0]  ra;
    logic [1:0]  rl;
    logic [31:0] rwd;
    logic        rw;

    tbl[0] = '{"st1",    1'b1, 8'h03, 2'd0, 32'h000000A5, 32'h00000000, 1'b0, 2, 0};
    tbl[1] = '{"ld1",    1'b0, 8'h03, 2'd0, 32'h00000000, 32'h000000A5, 1'b0, 3, 5};
    tbl[2] = '{"st4",    1'b1, 8'h1C, 2'd3, 32'h44332211, 32'h00000000, 1'b0, 5, 0};
    tbl[3] = '{"ld4",    1'b0, 8'h1C, 2'd3, 32'h00000000, 32'h44332211, 1'b0, 9, 0};
    tbl[4] = '{"ld_oor", 1'b0, 8'h1E, 2'd3, 32'h00000000, 32'h00004433, 1'b1, 7, 0};
    tbl[5] = '{"st_wrap",1'b1, 8'hFF, 2'd1, 32'h0000BB77, 32'h00000000, 1'b1, 3, 0};
    tbl[6] = '{"ld_zero",1'b0, 8'h00, 2'd0, 32'h00000000, 32'h000000BB, 1'b0, 3, 2};

    ref_init();
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst mem_wr", 32'(memoryWrite), 32'd0);
    chk("rst mem_rd", 32'(memory_read), 32'd0);
    chk("rst mem_addr", 32'(memory_address), 32'd0);
    chk("rst mem_wdata", 32'(memory_datawrite), 32'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      model(tbl[t].w, tbl[t].a, tbl[t].l, tbl[t].wd, m_rd, m_err, m_lat);
      run_req(tbl[t].name, tbl[t].w, tbl[t].a, tbl[t].l, tbl[t].wd,
              tbl[t].rd, tbl[t].err, tbl[t].lat, tbl[t].hold);
    end
`ifdef LSU_STATS_EN
    chk("stat_loads", 32'(stat_loads), 32'(n_loads));
    chk("stat_stores", 32'(stat_stores), 32'(n_stores));
    chk("stat_errs", 32'(stat_errs), 32'(n_errs));
`endif

    // Reset while a load sits in its read-wait cycle.
    @(negedge clk);
    req_write = 1'b0; req_addr = 8'h05; req_len = 2'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst rd_before", 32'(memory_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst rd_drop", 32'(memory_read), 32'd0);
    chk("midrst wr_low", 32'(memoryWrite), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_init();
    n_loads = 0; n_stores = 0; n_errs = 0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst ready_after", 32'(req_ready), 32'd1);
`ifdef LSU_STATS_EN
    chk("midrst stat_loads", 32'(stat_loads), 32'd0);
    chk("midrst stat_stores", 32'(stat_stores), 32'd0);
    chk("midrst stat_errs", 32'(stat_errs), 32'd0);
`endif

    for (int r = 0; r < 40; r++) begin
      rw  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 34));
      rl  = 2'($urandom_range(0, 3));
      rwd = $urandom;
      model(rw, ra, rl, rwd, m_rd, m_err, m_lat);
      run_req("rand", rw, ra, rl, rwd, m_rd, m_err, m_lat, $urandom_range(0, 2));
    end
`ifdef LSU_STATS_EN
    chk("end stat_loads", 32'(stat_loads), 32'(n_loads));
    chk("end stat_stores", 32'(stat_stores), 32'(n_stores));
    chk("end stat_errs", 32'(stat_errs), 32'(n_errs));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
